// File: rtl/pixel_memory_arb.sv
// Dual-port pixel RAM. Port A is shared by NUM_REQ requesters through a round-robin
// arbiter, and port B is a dedicated port. Reads on either port return registered data after one cycle.
module pixel_memory_arb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wen,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [DATA_W-1:0]         q_a,
    output logic                      q_a_valid,
    output logic [ID_W-1:0]           q_a_id,
    input  logic [ADDR_W-1:0]         addr_b,
    input  logic [DATA_W-1:0]         data_b,
    input  logic                      en_b,
    input  logic                      wren_b,
    output logic [DATA_W-1:0]         q_b,
    output logic                      q_b_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    // Handshake: requester i is served in the cycle where req_valid[i] & req_grant[i] is high.
    // Until that cycle it holds valid, wen, addr and data stable. Dropping valid earlier abandons the request.

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   ptr_next;
    logic [ID_W:0]     cand;
    logic              found;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_wen;
    logic              a_rd;
    logic              a_wr;
    logic              b_rd;
    logic              b_wr;

    // Search ptr, ptr+1, ... modulo NUM_REQ. ptr < NUM_REQ always holds, so one wrap step is enough.
    always_comb begin
        req_grant = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
        if (found)
            req_grant[gnt_idx] = 1'b1;
    end

    assign ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    assign a_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign a_data = req_data[gnt_idx*DATA_W +: DATA_W];
    assign a_wen  = req_wen[gnt_idx];

    // While reset is asserted, grants can still be seen on req_grant, but no access is performed.
    assign a_rd = found & ~a_wen;
    assign a_wr = found & a_wen & n_rst;
    assign b_rd = en_b & ~wren_b;
    assign b_wr = en_b & wren_b & n_rst;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr       <= '0;
            q_a       <= '0;
            q_a_valid <= 1'b0;
            q_a_id    <= '0;
            q_b       <= '0;
            q_b_valid <= 1'b0;
        end else begin
            if (found)
                ptr <= ptr_next;
            q_a_valid <= a_rd;
            if (a_rd) begin
                q_a    <= mem[a_addr];
                q_a_id <= gnt_idx;
            end
            q_b_valid <= b_rd;
            if (b_rd)
                q_b <= mem[addr_b];
        end
    end

    // Port A is written last, so it wins a same-address collision. Reads see the pre-edge contents.
    always_ff @(posedge clk) begin
        if (b_wr)
            mem[addr_b] <= data_b;
        if (a_wr)
            mem[a_addr] <= a_data;
    end

endmodule

// File: tb/tb_pixel_memory_arb.sv
// Directed bench for pixel_memory_arb with three requesters. A scoreboard queue per read port
// is filled as reads are issued and drained by a monitor whenever a valid appears.
`timescale 1ns/100ps
module tb_pixel_memory_arb;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;

    // clock / reset
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wen;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_grant;
    logic [DATA_W-1:0]         q_a;
    logic                      q_a_valid;
    logic [ID_W-1:0]           q_a_id;
    logic [ADDR_W-1:0]         addr_b;
    logic [DATA_W-1:0]         data_b;
    logic                      en_b;
    logic                      wren_b;
    logic [DATA_W-1:0]         q_b;
    logic                      q_b_valid;

    pixel_memory_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_REQ(NUM_REQ)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .req_valid(req_valid),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_grant(req_grant),
        .q_a      (q_a),
        .q_a_valid(q_a_valid),
        .q_a_id   (q_a_id),
        .addr_b   (addr_b),
        .data_b   (data_b),
        .en_b     (en_b),
        .wren_b   (wren_b),
        .q_b      (q_b),
        .q_b_valid(q_b_valid)
    );

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [ID_W+DATA_W-1:0] exp_a_q[$];
    logic [DATA_W-1:0]      exp_b_q[$];
    logic [ID_W+DATA_W-1:0] ea;
    logic [DATA_W-1:0]      eb;

    int rr_exp [12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 2, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q_a_valid) begin
            if (exp_a_q.size() == 0) begin
                check("q_a_valid unexpected", 32'(q_a_valid), 32'd0);
            end else begin
                ea = exp_a_q.pop_front();
                check("q_a data", 32'(q_a), 32'(ea[DATA_W-1:0]));
                check("q_a_id", 32'(q_a_id), 32'(ea[ID_W+DATA_W-1:DATA_W]));
            end
        end
        if (q_b_valid) begin
            if (exp_b_q.size() == 0) begin
                check("q_b_valid unexpected", 32'(q_b_valid), 32'd0);
            end else begin
                eb = exp_b_q.pop_front();
                check("q_b data", 32'(q_b), 32'(eb));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i]                = v;
        req_wen[i]                  = w;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic port_b(input logic e, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        en_b   = e;
        wren_b = w;
        addr_b = a;
        data_b = d;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_wen   = '0;
        en_b      = 1'b0;
        wren_b    = 1'b0;
    endtask

    task automatic push_a(input int id, input logic [DATA_W-1:0] d);
        exp_a_q.push_back({ID_W'(id), d});
    endtask

    task automatic check_grant(input string name, input logic [NUM_REQ-1:0] exp);
        #2;
        check(name, 32'(req_grant), 32'(exp));
    endtask

    initial begin
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_data  = '0;
        port_b(1'b0, 1'b0, '0, '0);

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset q_a", 32'(q_a), 32'd0);
        check("reset q_a_valid", 32'(q_a_valid), 32'd0);
        check("reset q_a_id", 32'(q_a_id), 32'd0);
        check("reset q_b", 32'(q_b), 32'd0);
        check("reset q_b_valid", 32'(q_b_valid), 32'd0);
        check("idle grant", 32'(req_grant), 32'd0);
        n_rst = 1'b1;

        // round robin: all three write continuously, then req 1 drops out
        set_req(0, 1'b1, 1'b1, 10'h100, 16'hA000);
        set_req(1, 1'b1, 1'b1, 10'h101, 16'hA001);
        set_req(2, 1'b1, 1'b1, 10'h102, 16'hA002);
        for (int c = 0; c < 12; c++) begin
            if (c == 9) req_valid[1] = 1'b0;
            check_grant("rr grant", NUM_REQ'(1 << rr_exp[c]));
            tick();
        end
        clear_all();
        for (int i = 0; i < 3; i++) begin
            port_b(1'b1, 1'b0, 10'(10'h100 + i), '0);
            exp_b_q.push_back(16'(16'hA000 + i));
            tick();
        end
        clear_all();

        // single requester write then read at the top address
        set_req(1, 1'b1, 1'b1, 10'h3FF, 16'hBEEF);
        check_grant("single wr grant", 3'b010);
        tick();
        set_req(1, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        push_a(1, 16'hBEEF);
        check_grant("single rd grant", 3'b010);
        tick();
        clear_all();

        // same-address write collision: port A wins
        set_req(0, 1'b1, 1'b1, 10'h005, 16'h1111);
        port_b(1'b1, 1'b1, 10'h005, 16'h2222);
        check_grant("collision grant", 3'b001);
        tick();
        clear_all();
        port_b(1'b1, 1'b0, 10'h005, '0);
        exp_b_q.push_back(16'h1111);
        tick();

        // port B read during port A write returns old data
        port_b(1'b1, 1'b1, 10'h010, 16'hAAAA);
        tick();
        set_req(2, 1'b1, 1'b1, 10'h010, 16'h5555);
        port_b(1'b1, 1'b0, 10'h010, '0);
        exp_b_q.push_back(16'hAAAA);
        check_grant("rdw b grant", 3'b100);
        tick();
        clear_all();
        port_b(1'b1, 1'b0, 10'h010, '0);
        exp_b_q.push_back(16'h5555);
        tick();

        // port A read during port B write returns old data
        port_b(1'b1, 1'b1, 10'h020, 16'h1234);
        tick();
        set_req(0, 1'b1, 1'b0, 10'h020, '0);
        port_b(1'b1, 1'b1, 10'h020, 16'h4321);
        push_a(0, 16'h1234);
        check_grant("rdw a grant", 3'b001);
        tick();
        clear_all();
        port_b(1'b1, 1'b0, 10'h020, '0);
        exp_b_q.push_back(16'h4321);
        tick();

        // abandoned request: preset 0x031, steer ptr to 0 via a req 2 grant
        port_b(1'b1, 1'b1, 10'h031, 16'h5A5A);
        tick();
        clear_all();
        set_req(2, 1'b1, 1'b1, 10'h032, 16'h0002);
        check_grant("abandon setup grant", 3'b100);
        tick();
        clear_all();
        set_req(0, 1'b1, 1'b1, 10'h030, 16'h0C0C);
        set_req(1, 1'b1, 1'b1, 10'h031, 16'hDEAD);
        check_grant("abandon req0 grant", 3'b001);
        tick();
        clear_all();
        check_grant("abandon idle grant", 3'b000);
        tick();
        set_req(0, 1'b1, 1'b1, 10'h033, 16'h7777);
        set_req(1, 1'b1, 1'b0, 10'h031, '0);
        port_b(1'b1, 1'b1, 10'h040, 16'h0404);
        push_a(1, 16'h5A5A);
        check_grant("abandon ptr grant", 3'b010);
        tick();
        clear_all();
        port_b(1'b1, 1'b0, 10'h030, '0);
        exp_b_q.push_back(16'h0C0C);
        tick();

        // reset asserted just before an edge that carries granted reads on both ports
        clear_all();
        set_req(1, 1'b1, 1'b0, 10'h3FF, '0);
        port_b(1'b1, 1'b0, 10'h3FF, '0);
        check_grant("pre-reset grant", 3'b010);
        #5;
        n_rst = 1'b0;
        #1;
        check("async q_a", 32'(q_a), 32'd0);
        check("async q_a_valid", 32'(q_a_valid), 32'd0);
        check("async q_a_id", 32'(q_a_id), 32'd0);
        check("async q_b", 32'(q_b), 32'd0);
        check("async q_b_valid", 32'(q_b_valid), 32'd0);
        @(posedge clk);
        #1;
        check("discarded q_a_valid", 32'(q_a_valid), 32'd0);
        check("discarded q_b_valid", 32'(q_b_valid), 32'd0);
        clear_all();
        set_req(0, 1'b1, 1'b1, 10'h040, 16'hFFFF);
        check_grant("in-reset grant", 3'b001);
        tick();
        clear_all();
        n_rst = 1'b1;
        set_req(1, 1'b1, 1'b0, 10'h040, '0);
        set_req(2, 1'b1, 1'b0, 10'h3FF, '0);
        push_a(1, 16'h0404);
        check_grant("post-reset grant", 3'b010);
        tick();
        req_valid[1] = 1'b0;
        push_a(2, 16'hBEEF);
        check_grant("post-reset next grant", 3'b100);
        tick();
        clear_all();
        repeat (3) tick();

        check("exp_a_q drained", 32'(exp_a_q.size()), 32'd0);
        check("exp_b_q drained", 32'(exp_b_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
